timing_cfg_sequencer: RTL and testbench
=======================================

Name: timing_cfg_sequencer

Overview:
Controller that turns the five operator-entered BCD timing fields into the four pulse-count timings used by the Morse encoder/decoder.
- A single serial BCD-to-binary datapath and a single shift-add multiplier are time-shared across all fields, instead of five converters and four parallel multipliers.
- Validates the fields.
- Commits all four timings atomically, and only while the consumer reports idle.
- Sits between the settings/keypad front end and the Morse timing consumers.

Parameters:
DIGITS, `UNIT_BCD_W (3), BCD digits per field
HALF_W, `PULSE_CNT_HALF_W (10), binary width of one converted field
OUT_W, `PULSE_CNT_W (20), timing output width; must equal 2*HALF_W

Ports:
clk  in  1  system clock; the only clock
rst_n  in  1  asynchronous, active-low reset
ce  in  1  clock enable; every state change is gated by ce
update  in  1  request a recompute from the current BCD inputs
consumer_busy  in  1  consumer mid-symbol; commit is deferred while high
dit_units, dah_units, word_units, tol_units, pulses_per_unit  in  4*DIGITS each  BCD fields
dit_time, dah_time, word_time, tol_time  out  OUT_W each  committed timings (registered)
cfg_valid  out  1  high once at least one commit has succeeded
ready  out  1  high in IDLE with no pending request
done  out  1  one-ce-cycle pulse on the commit edge
err  out  1  sticky error from the last run; cleared on the next accepted update

Behaviour:
Interface decisions:
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Reset:
- All timings = 0, cfg_valid = 0, err = 0, done = 0, ready = 1.
- State = IDLE, pending flag = 0, internal registers = 0.
- Reset asserted mid-operation aborts the run and discards all partial results.

Update acceptance (edge k):
- Condition: ce & update in IDLE.
- Snapshot all five fields.
- Clear err; set ready = 0.
- Go to CONV.

State CONV:
- 5*DIGITS ce-cycles.
- Fields are processed in order dit, dah, word, tol, ppu, most significant digit first.
- Per step: acc <= acc*10 + digit, computed as (acc<<3) + (acc<<1) + digit.
- Any digit > 9 sets an internal bad flag.
- The last step completes on edge k+5*DIGITS; then go to CHECK.

State CHECK (1 cycle):
- If bad, or dit = 0, or ppu = 0: go to ERR.
- Otherwise go to MUL.
- dah, word and tol may be 0.

State MUL:
- 4*HALF_W ce-cycles, products in the order dit, dah, word, tol.
- Each product uses the unsigned shift-add multiplier: HALF_W iterations, 2*HALF_W-bit result, no overflow possible.
- Results go to shadow registers; the output registers are untouched.

State COMMIT_WAIT:
- On the first ce edge with consumer_busy = 0: copy all four shadows to the outputs in the same edge, set cfg_valid = 1, pulse done.
- Minimum commit edge is k + 2 + 5*DIGITS + 4*HALF_W (k+57 at the defaults).
- While consumer_busy = 1: wait indefinitely.

State ERR (1 cycle):
- Set err = 1.
- Outputs and cfg_valid keep their previous values.
- No done pulse.

ce = 0:
- Full stall: no state, counter or output change.
- done stays high until the next ce edge.

Update while not IDLE:
- Sets pending; does not restart the current run.
- On leaving COMMIT_WAIT or ERR with pending set: clear pending, re-snapshot, and enter CONV directly (no IDLE cycle).
- ready stays 0 throughout.

Other rules:
- An update on the same edge as a commit counts as pending.
- ready = (state == IDLE) & !pending.

Decomposition:
Shared header defines.vh:
- `UNIT_BCD_W, `PULSE_CNT_HALF_W, `PULSE_CNT_W.
- State encodings: IDLE, CONV, CHECK, MUL, COMMIT_WAIT, ERR.

Sub-module seq_mul_u:
- Parameter W.
- Ports: start, a, b, product, busy.
- Unsigned shift-add multiply, W cycles, own ce and asynchronous reset.

The BCD accumulator and field/digit counters stay inline in the sequencer.

Test Plan:
1. Basic conversion:
   - Stimulus: dit=001, dah=003, word=007, tol=000, ppu=250; pulse update at edge k with consumer_busy = 0.
   - Required: done at k+57; outputs 250/750/1750/0; cfg_valid = 1; err = 0; ready back high the following cycle.
2. Maximum values:
   - Stimulus: all fields = 999.
   - Required: every timing = 998001, exactly 20 bits with no truncation.
3. Error cases:
   - Stimulus: tol = 0x1A3 (invalid digit) after a good commit; separately, dit = 000.
   - Required: err = 1, no done pulse, previous outputs and cfg_valid unchanged.
   - A following valid update clears err.
4. Deferred commit:
   - Stimulus: consumer_busy held high from k to k+80.
   - Required: outputs unchanged until the first edge with consumer_busy low after k+57; then all four change on that single edge.
5. Update mid-run:
   - Stimulus: second update at k+10 with ppu changed to 100.
   - Required: first run commits at k+57; second run re-snapshots on that edge and commits at k+114 with ppu = 100 values; ready stays low throughout.
6. Reset and stall:
   - Stimulus: rst_n low during MUL.
   - Required: timings 0, cfg_valid 0, ready 1.
   - Separately, ce held low for 5 cycles mid-CONV delays done by exactly 5 clk cycles.

Source files
------------

// File: rtl/timing_cfg_sequencer_pkg.sv
// Shared sizes, state encoding and the BCD accumulate step for the timing
// configuration sequencer.
package timing_cfg_sequencer_pkg;

  localparam int DIGITS     = 3;            // BCD digits per field
  localparam int HALF_W     = 10;           // binary width of one converted field
  localparam int OUT_W      = 2 * HALF_W;   // width of one committed timing
  localparam int BCD_W      = 4 * DIGITS;
  localparam int NFIELDS    = 5;            // dit, dah, word, tol, ppu
  localparam int NPROD      = 4;            // dit, dah, word, tol times ppu
  localparam int FIELD_W    = $clog2(NFIELDS);
  localparam int DIGIT_W    = $clog2(DIGITS);
  localparam int PROD_W     = $clog2(NPROD);
  localparam int BIT_W      = $clog2(HALF_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_CHECK,
    S_MUL,
    S_COMMIT_WAIT,
    S_ERR
  } state_t;

  // acc*10 + digit using only shifts and adds; wraps silently on bad digits,
  // which is harmless because such a run is rejected anyway.
  function automatic logic [HALF_W-1:0] bcd_step(input logic [HALF_W-1:0] acc,
                                                 input logic [3:0]        digit);
    logic [HALF_W+3:0] wide;
    wide = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{HALF_W{1'b0}}, digit};
    return wide[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/timing_cfg_sequencer_if.sv
// Control, BCD field and timing output bundle between the settings front end
// (master) and the sequencer (slave).
interface timing_cfg_sequencer_if;
  import timing_cfg_sequencer_pkg::*;

  logic             ce;
  logic             update;
  logic             consumer_busy;
  logic [BCD_W-1:0] dit_units;
  logic [BCD_W-1:0] dah_units;
  logic [BCD_W-1:0] word_units;
  logic [BCD_W-1:0] tol_units;
  logic [BCD_W-1:0] pulses_per_unit;
  logic [OUT_W-1:0] dit_time;
  logic [OUT_W-1:0] dah_time;
  logic [OUT_W-1:0] word_time;
  logic [OUT_W-1:0] tol_time;
  logic             cfg_valid;
  logic             ready;
  logic             done;
  logic             err;

  modport master (
    output ce, update, consumer_busy,
    output dit_units, dah_units, word_units, tol_units, pulses_per_unit,
    input  dit_time, dah_time, word_time, tol_time,
    input  cfg_valid, ready, done, err
  );

  modport slave (
    input  ce, update, consumer_busy,
    input  dit_units, dah_units, word_units, tol_units, pulses_per_unit,
    output dit_time, dah_time, word_time, tol_time,
    output cfg_valid, ready, done, err
  );

endinterface

// File: rtl/timing_cfg_sequencer_seq_mul_u.sv
// Unsigned shift-add multiplier. The start cycle already retires bit 0 of b,
// so a full product takes exactly W ce-cycles and products can be issued
// back to back with no gap.
module seq_mul_u #(
  parameter int W = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           busy
);
  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;

  // One partial product per ce-cycle; the result holds until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (ce) begin
      if (start) begin
        acc_q    <= b[0] ? {{W{1'b0}}, a} : '0;
        mcand_q  <= {{W{1'b0}}, a} << 1;
        mplier_q <= b >> 1;
        cnt_q    <= CW'(W - 1);
        busy_q   <= (W > 1);
      end else if (busy_q) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CW'(1);
        busy_q   <= (cnt_q != CW'(1));
      end
    end
  end

  assign product = acc_q;
  assign busy    = busy_q;

endmodule

// File: rtl/timing_cfg_sequencer.sv
// Converts five BCD timing fields into four pulse-count timings with one
// time-shared serial BCD converter and one shift-add multiplier, validates
// them and commits all four at once while the consumer is idle.
module timing_cfg_sequencer
  import timing_cfg_sequencer_pkg::*;
(
  input logic                   clk,
  input logic                   rst_n,
  timing_cfg_sequencer_if.slave bus
);

  state_t              state_q, state_d;
  logic                pending_q, pending_d;
  logic [BCD_W-1:0]    snap_q   [NFIELDS];
  logic [HALF_W-1:0]   bin_q    [NFIELDS];
  logic [HALF_W-1:0]   acc_q;
  logic                bad_q;
  logic [FIELD_W-1:0]  field_q;
  logic [DIGIT_W-1:0]  digit_q;
  logic [PROD_W-1:0]   prod_q;
  logic [BIT_W-1:0]    bit_q;
  logic [OUT_W-1:0]    shadow_q [NPROD-1];
  logic [OUT_W-1:0]    time_q   [NPROD];
  logic                cfg_valid_q, done_q, err_q;

  logic                accept, commit, to_err, last_digit;
  logic [BCD_W-1:0]    cur_field;
  logic [3:0]          cur_digit;
  logic [HALF_W-1:0]   acc_next;
  logic [PROD_W-1:0]   prod_prev;
  logic                mul_start, mul_busy;
  logic [OUT_W-1:0]    mul_product;

  // Select the current digit (MSD first) and form the next accumulator value.
  always_comb begin
    cur_field  = snap_q[field_q];
    cur_digit  = cur_field[4*(DIGITS-1-int'(digit_q)) +: 4];
    acc_next   = bcd_step(acc_q, cur_digit);
    last_digit = (digit_q == DIGIT_W'(DIGITS - 1));
    prod_prev  = prod_q - PROD_W'(1);
    mul_start  = (state_q == S_MUL) && (bit_q == '0);
  end

  // Next-state decode plus the accept/commit/error strobes for the datapath.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    commit    = 1'b0;
    to_err    = 1'b0;
    pending_d = pending_q | (bus.update && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (bus.update || pending_q) begin
          accept  = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (last_digit && (field_q == FIELD_W'(NFIELDS - 1))) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (bad_q || (bin_q[0] == '0) || (bin_q[NFIELDS-1] == '0)) begin
          to_err  = 1'b1;
          state_d = S_ERR;
        end else begin
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if ((prod_q == PROD_W'(NPROD - 1)) && (bit_q == BIT_W'(HALF_W - 1)))
          state_d = S_COMMIT_WAIT;
      end
      S_COMMIT_WAIT: begin
        if (!bus.consumer_busy && !mul_busy) begin
          commit  = 1'b1;
          accept  = pending_q;
          state_d = pending_q ? S_CONV : S_IDLE;
        end
      end
      S_ERR: begin
        accept  = pending_q;
        state_d = pending_q ? S_CONV : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A request arriving on the very edge that consumes the pending flag
    // must survive into the following run.
    if (accept) pending_d = bus.update && (state_q != S_IDLE);
  end

  // State and pending-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
    end else if (bus.ce) begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Snapshot, BCD conversion, product sequencing, shadows and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NFIELDS; i++) begin
        snap_q[i] <= '0;
        bin_q[i]  <= '0;
      end
      for (int i = 0; i < NPROD - 1; i++) shadow_q[i] <= '0;
      for (int i = 0; i < NPROD; i++)     time_q[i]   <= '0;
      acc_q       <= '0;
      bad_q       <= 1'b0;
      field_q     <= '0;
      digit_q     <= '0;
      prod_q      <= '0;
      bit_q       <= '0;
      cfg_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (bus.ce) begin
      done_q <= commit;
      if (accept) begin
        snap_q[0] <= bus.dit_units;
        snap_q[1] <= bus.dah_units;
        snap_q[2] <= bus.word_units;
        snap_q[3] <= bus.tol_units;
        snap_q[4] <= bus.pulses_per_unit;
        acc_q     <= '0;
        bad_q     <= 1'b0;
        field_q   <= '0;
        digit_q   <= '0;
        prod_q    <= '0;
        bit_q     <= '0;
        err_q     <= 1'b0;
      end
      if (state_q == S_CONV) begin
        bad_q <= bad_q | (cur_digit > 4'd9);
        if (last_digit) begin
          bin_q[field_q] <= acc_next;
          acc_q          <= '0;
          digit_q        <= '0;
          field_q        <= field_q + FIELD_W'(1);
        end else begin
          acc_q   <= acc_next;
          digit_q <= digit_q + DIGIT_W'(1);
        end
      end
      if (to_err) err_q <= 1'b1;
      // Each new start retires the previous product into its shadow; the
      // final (tol) product stays in the multiplier until commit.
      if (state_q == S_MUL) begin
        if ((bit_q == '0) && (prod_q != '0)) shadow_q[prod_prev] <= mul_product;
        if (bit_q == BIT_W'(HALF_W - 1)) begin
          bit_q  <= '0;
          prod_q <= prod_q + PROD_W'(1);
        end else begin
          bit_q <= bit_q + BIT_W'(1);
        end
      end
      if (commit) begin
        time_q[0]   <= shadow_q[0];
        time_q[1]   <= shadow_q[1];
        time_q[2]   <= shadow_q[2];
        time_q[3]   <= mul_product;
        cfg_valid_q <= 1'b1;
      end
    end
  end

  seq_mul_u #(.W(HALF_W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce      (bus.ce),
    .start   (mul_start),
    .a       (bin_q[prod_q]),
    .b       (bin_q[NFIELDS-1]),
    .product (mul_product),
    .busy    (mul_busy)
  );

  assign bus.dit_time  = time_q[0];
  assign bus.dah_time  = time_q[1];
  assign bus.word_time = time_q[2];
  assign bus.tol_time  = time_q[3];
  assign bus.cfg_valid = cfg_valid_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.ready     = (state_q == S_IDLE) && !pending_q;

endmodule

// File: tb/tb_timing_cfg_sequencer.sv
// Scoreboard bench: stimulus pushes the expected outcome of each update,
// a monitor pops and compares on every done pulse or err rise.
module tb_timing_cfg_sequencer;
  import timing_cfg_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  timing_cfg_sequencer_if bus();
  timing_cfg_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit is_err;
    int d, a, w, t;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0, miscompares = 0, cyc = 0;
  int   last_d = 0, last_a = 0, last_w = 0, last_t = 0;
  int   last_valid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Decimal value of a 3-digit BCD field; ok clears on any nibble above 9.
  function automatic int bcd_value(input logic [11:0] f, output bit ok);
    int h, t, u;
    h = int'(f[11:8]);
    t = int'(f[7:4]);
    u = int'(f[3:0]);
    ok = (h <= 9) && (t <= 9) && (u <= 9);
    return h * 100 + t * 10 + u;
  endfunction

  function automatic exp_t model(input logic [11:0] fd, fa, fw, ft, fp, input int c);
    exp_t m;
    bit o0, o1, o2, o3, o4;
    int vd, va, vw, vt, vp;
    vd = bcd_value(fd, o0);
    va = bcd_value(fa, o1);
    vw = bcd_value(fw, o2);
    vt = bcd_value(ft, o3);
    vp = bcd_value(fp, o4);
    m.is_err = !(o0 && o1 && o2 && o3 && o4) || (vd == 0) || (vp == 0);
    m.d = vd * vp;
    m.a = va * vp;
    m.w = vw * vp;
    m.t = vt * vp;
    m.cyc = c;
    return m;
  endfunction

  // Drive one update pulse; k is the edge that samples it. off < 0 means
  // the commit cycle is not checked.
  task automatic issue(input logic [11:0] fd, fa, fw, ft, fp, input int off, output int k);
    @(negedge clk);
    bus.dit_units = fd;
    bus.dah_units = fa;
    bus.word_units = fw;
    bus.tol_units = ft;
    bus.pulses_per_unit = fp;
    bus.update = 1'b1;
    k = cyc + 1;
    sb.push_back(model(fd, fa, fw, ft, fp, (off < 0) ? -1 : k + off));
    @(negedge clk);
    bus.update = 1'b0;
  endtask

  task automatic drain(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.ready && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, "_drain_timeout"}, ok, 1);
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic logic [11:0] rand_field(input bit allow_bad);
    logic [11:0] f;
    for (int i = 0; i < 3; i++) f[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad) f[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
    return f;
  endfunction

  // Monitor: one line per observed transaction.
  initial begin
    bit dprev = 1'b0, eprev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dprev = 1'b0;
        eprev = 1'b0;
      end else begin
        if (bus.done && !dprev) begin
          if (sb.size() == 0) chk("unexpected_done", 0, 1);
          else begin
            e = sb.pop_front();
            $display("commit @%0d: %0d %0d %0d %0d", cyc, bus.dit_time, bus.dah_time,
                     bus.word_time, bus.tol_time);
            chk("commit_kind", e.is_err, 0);
            chk("dit_time", bus.dit_time, e.d);
            chk("dah_time", bus.dah_time, e.a);
            chk("word_time", bus.word_time, e.w);
            chk("tol_time", bus.tol_time, e.t);
            chk("commit_cfg_valid", bus.cfg_valid, 1);
            chk("commit_err", bus.err, 0);
            if (e.cyc >= 0) chk("commit_cycle", cyc, e.cyc);
            last_d = e.d; last_a = e.a; last_w = e.w; last_t = e.t;
            last_valid = 1;
          end
        end
        if (bus.err && !eprev) begin
          if (sb.size() == 0) chk("unexpected_err", 0, 1);
          else begin
            e = sb.pop_front();
            $display("error  @%0d: outputs held %0d %0d %0d %0d", cyc, bus.dit_time,
                     bus.dah_time, bus.word_time, bus.tol_time);
            chk("err_kind", e.is_err, 1);
            chk("err_dit_hold", bus.dit_time, last_d);
            chk("err_dah_hold", bus.dah_time, last_a);
            chk("err_word_hold", bus.word_time, last_w);
            chk("err_tol_hold", bus.tol_time, last_t);
            chk("err_cfg_valid_hold", bus.cfg_valid, last_valid);
            chk("err_no_done", bus.done, 0);
          end
        end
        dprev = bus.done;
        eprev = bus.err;
      end
    end
  end

  initial begin
    int k, ka, kb;
    bit seen, ready_low;
    bus.ce = 1'b1;
    bus.update = 1'b0;
    bus.consumer_busy = 1'b0;
    bus.dit_units = '0; bus.dah_units = '0; bus.word_units = '0;
    bus.tol_units = '0; bus.pulses_per_unit = '0;
    repeat (3) @(negedge clk);
    chk("rst_dit", bus.dit_time, 0);
    chk("rst_tol", bus.tol_time, 0);
    chk("rst_cfg_valid", bus.cfg_valid, 0);
    chk("rst_ready", bus.ready, 1);
    chk("rst_err", bus.err, 0);
    chk("rst_done", bus.done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic conversion, commit latency 57 and ready returning.
    issue(12'h001, 12'h003, 12'h007, 12'h000, 12'h250, 57, k);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done;
    end
    chk("t1_done_seen", seen, 1);
    chk("t1_ready_after", bus.ready, 1);
    drain("t1");

    // Maximum values.
    issue(12'h999, 12'h999, 12'h999, 12'h999, 12'h999, 57, k);
    drain("t2");

    // Invalid digit, then zero dit, then a valid update clearing err.
    issue(12'h002, 12'h004, 12'h006, 12'h1A3, 12'h010, -1, k);
    drain("t3a");
    chk("t3a_err_sticky", bus.err, 1);
    issue(12'h000, 12'h004, 12'h006, 12'h001, 12'h010, -1, k);
    drain("t3b");
    issue(12'h002, 12'h005, 12'h008, 12'h001, 12'h012, 57, k);
    drain("t3c");
    chk("t3c_err_cleared", bus.err, 0);

    // Deferred commit: consumer busy up to edge k+80.
    bus.consumer_busy = 1'b1;
    issue(12'h004, 12'h012, 12'h028, 12'h002, 12'h033, 81, k);
    wait_cycle(k + 70);
    chk("t4_hold_dit", bus.dit_time, last_d);
    chk("t4_hold_done", bus.done, 0);
    wait_cycle(k + 80);
    bus.consumer_busy = 1'b0;
    drain("t4");

    // Update mid-run: queued run re-snapshots on the first commit edge.
    issue(12'h003, 12'h009, 12'h021, 12'h001, 12'h250, 57, ka);
    wait_cycle(ka + 8);
    issue(12'h003, 12'h009, 12'h021, 12'h001, 12'h100, ka + 114 - (ka + 10), kb);
    ready_low = 1'b1;
    while (cyc < ka + 113) begin
      @(negedge clk);
      if (bus.ready) ready_low = 1'b0;
    end
    chk("t5_ready_low", ready_low, 1);
    drain("t5");

    // Five stalled ce cycles mid-CONV push the commit out by five.
    issue(12'h005, 12'h015, 12'h035, 12'h003, 12'h020, 62, k);
    wait_cycle(k + 5);
    bus.ce = 1'b0;
    repeat (5) @(negedge clk);
    bus.ce = 1'b1;
    drain("t6_stall");

    // Reset during MUL discards the run and clears everything.
    issue(12'h007, 12'h021, 12'h049, 12'h002, 12'h111, 57, k);
    wait_cycle(k + 30);
    rst_n = 1'b0;
    sb.delete();
    last_d = 0; last_a = 0; last_w = 0; last_t = 0; last_valid = 0;
    #1;
    chk("t6_rst_dit", bus.dit_time, 0);
    chk("t6_rst_word", bus.word_time, 0);
    chk("t6_rst_cfg_valid", bus.cfg_valid, 0);
    chk("t6_rst_ready", bus.ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    issue(12'h001, 12'h003, 12'h007, 12'h000, 12'h064, 57, k);
    drain("t6_recover");

    // Randomized runs with occasional invalid fields.
    for (int n = 0; n < 24; n++) begin
      logic [11:0] f[5];
      int badsel;
      badsel = $urandom_range(0, 9);
      for (int i = 0; i < 5; i++) f[i] = rand_field(1'b0);
      if (badsel == 0) f[$urandom_range(0, 4)] = rand_field(1'b1);
      if (badsel == 1) f[0] = 12'h000;
      if (badsel == 2) f[4] = 12'h000;
      issue(f[0], f[1], f[2], f[3], f[4], 57, k);
      drain("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
